// File: rtl/crossover_ctrl_if.sv
// Parent-read / child-write stream bus driven by crossover_ctrl toward the gene memories and gene mux.
interface crossover_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_sel;

  modport master (
    output rd_en, rd_addr, sel, wr_en, wr_addr, wr_sel
  );

  modport slave (
    input rd_en, rd_addr, sel, wr_en, wr_addr, wr_sel
  );
endinterface

// File: rtl/crossover_ctrl.sv
// Single-point crossover sequencer: picks a crossover point, streams parent reads, child writes one cycle later.
// Optional XOVER_FIXED_PT_EN replaces the LFSR pick with an externally supplied fixed_pt (clamped to min size).
module crossover_ctrl #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] SEED   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] genome1_size,
  input  logic [ADDR_W-1:0] genome2_size,
`ifdef XOVER_FIXED_PT_EN
  input  logic [ADDR_W-1:0] fixed_pt,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] crossover_pt,
  crossover_ctrl_if.master  mem
);

  typedef enum logic [1:0] {IDLE, PICK, STREAM, END} state_t;

  state_t            state;
  logic [ADDR_W-1:0] size2;
  logic [ADDR_W-1:0] min_size;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] k_inc;
  logic [ADDR_W-1:0] k_last;
  logic              rd_en;
  logic [1:0]        sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_sel;
  logic              pick_ok;
  logic [ADDR_W-1:0] pick_val;

  assign k_inc  = k + ADDR_W'(1);
  assign k_last = size2 - ADDR_W'(1);

`ifdef XOVER_FIXED_PT_EN
  assign pick_ok  = 1'b1;
  assign pick_val = (fixed_pt <= min_size) ? fixed_pt : min_size;
`else
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // The LFSR never yields 0, so an empty shorter parent is resolved without drawing.
  assign pick_ok   = (min_size == '0) || (32'(lfsr) <= 32'(min_size));
  assign pick_val  = (min_size == '0) ? '0 : ADDR_W'(lfsr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= SEED;
    else if (state == PICK && min_size != '0)
      lfsr <= lfsr_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      size2        <= '0;
      min_size     <= '0;
      k            <= '0;
      crossover_pt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_en        <= 1'b0;
      sel          <= 2'b00;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_sel       <= 2'b00;
    end else begin
      wr_en   <= rd_en;
      wr_addr <= k;
      wr_sel  <= sel;
      case (state)
        IDLE: begin
          if (start) begin
            size2    <= genome2_size;
            min_size <= (genome1_size < genome2_size) ? genome1_size : genome2_size;
            busy     <= 1'b1;
            state    <= PICK;
          end
        end
        PICK: begin
          if (pick_ok) begin
            crossover_pt <= pick_val;
            k            <= '0;
            if (size2 == '0) begin
              sel   <= 2'b01;
              done  <= 1'b1;
              state <= END;
            end else begin
              rd_en <= 1'b1;
              sel   <= (pick_val != '0) ? 2'b10 : 2'b11;
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (k == k_last) begin
            rd_en <= 1'b0;
            sel   <= 2'b01;
            done  <= 1'b1;
            k     <= '0;
            state <= END;
          end else begin
            k   <= k_inc;
            sel <= (k_inc < crossover_pt) ? 2'b10 : 2'b11;
          end
        end
        END: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          sel   <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.rd_en   = rd_en;
  assign mem.rd_addr = k;
  assign mem.sel     = sel;
  assign mem.wr_en   = wr_en;
  assign mem.wr_addr = wr_addr;
  assign mem.wr_sel  = wr_sel;

endmodule
